// File: rtl/gsim_sequencer.sv
// gsim_sequencer: control sequencer for the banded Gauss-Seidel solver.
// Loads N b words, runs ITER sweeps of row issues, tracks the LAT-deep
// compute pipeline for x write-back, then streams x out (valid/ready).
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   in_en            b word present on the data bus
//   b_wr_en/addr     b register-file write strobe and index
//   issue_valid/row  row evaluated by the compute unit this cycle
//   nbr_valid        {i-1,i+1,i-2,i+2,i-3,i+3} in-range mask
//   x_wr_en/addr     compute result write-back, LAT after issue
//   out_valid/ready  output handshake, out_addr selects x word
//   busy, done       not idle; one-cycle completion pulse
// Build option: define GSIM_SEQ_PIPELINED_EN to issue rows back to back
// (hybrid Jacobi/GS); otherwise each row waits LAT+1 cycles.

module gsim_sequencer #(
  parameter int N    = 16,
  parameter int ITER = 50,
  parameter int LAT  = 2,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_en,
  output logic            b_wr_en,
  output logic [IDXW-1:0] b_wr_addr,
  output logic            issue_valid,
  output logic [IDXW-1:0] issue_row,
  output logic [5:0]      nbr_valid,
  output logic            x_wr_en,
  output logic [IDXW-1:0] x_wr_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_addr,
  output logic            busy,
  output logic            done
);

`ifdef GSIM_SEQ_PIPELINED_EN
  localparam int P = 1;
`else
  localparam int P = LAT + 1;
`endif

  localparam int SW = $clog2(ITER + 1);
  localparam int PW = $clog2(LAT + 2);
  localparam int DW = $clog2(LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t          r_state;
  logic [IDXW-1:0] r_load_cnt;
  logic            r_issue_valid;
  logic [IDXW-1:0] r_issue_row;
  logic [5:0]      r_nbr;
  logic [SW-1:0]   r_sweep;
  logic [PW-1:0]   r_ph;
  logic [DW-1:0]   r_dcnt;
  logic            r_out_valid;
  logic [IDXW-1:0] r_out_addr;
  logic            r_done;

  logic [LAT-1:0]  r_pv;
  logic [IDXW-1:0] r_prow [LAT];

  logic            w_ld_ok;
  logic            w_last_row;
  logic            w_last_issue;
  logic [IDXW-1:0] w_next_row;

  // In-range test of each banded neighbour of row i.
  function automatic logic [5:0] f_mask(input logic [IDXW-1:0] row);
    int i;
    i = int'(row);
    f_mask = {i >= 1, i + 1 <= N - 1,
              i >= 2, i + 2 <= N - 1,
              i >= 3, i + 3 <= N - 1};
  endfunction

  // Write strobe follows in_en in the same cycle so the datapath can
  // capture the word straight off the bus.
  assign w_ld_ok = in_en && !reset &&
                   (r_state == S_IDLE || r_state == S_LOAD);

  assign w_last_row = (r_issue_row == IDXW'(N - 1));
  assign w_next_row = w_last_row ? '0 : r_issue_row + IDXW'(1);
  assign w_last_issue = r_issue_valid && w_last_row &&
                        (r_sweep == SW'(ITER - 1));

  assign b_wr_en     = w_ld_ok;
  assign b_wr_addr   = (r_state == S_LOAD) ? r_load_cnt : '0;
  assign issue_valid = r_issue_valid;
  assign issue_row   = r_issue_row;
  assign nbr_valid   = r_nbr;
  assign x_wr_en     = r_pv[LAT-1];
  assign x_wr_addr   = r_prow[LAT-1];
  assign out_valid   = r_out_valid;
  assign out_addr    = r_out_addr;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_load_cnt    <= '0;
      r_issue_valid <= 1'b0;
      r_issue_row   <= '0;
      r_nbr         <= '0;
      r_sweep       <= '0;
      r_ph          <= '0;
      r_dcnt        <= '0;
      r_out_valid   <= 1'b0;
      r_out_addr    <= '0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (in_en) begin
            r_state    <= S_LOAD;
            r_load_cnt <= IDXW'(1);
          end
        end
        S_LOAD: begin
          if (in_en) begin
            if (r_load_cnt == IDXW'(N - 1)) begin
              // First issue lands the cycle after the last b word.
              r_state       <= S_ITER;
              r_load_cnt    <= '0;
              r_issue_valid <= 1'b1;
              r_issue_row   <= '0;
              r_nbr         <= f_mask('0);
              r_sweep       <= '0;
              r_ph          <= '0;
            end else begin
              r_load_cnt <= r_load_cnt + IDXW'(1);
            end
          end
        end
        S_ITER: begin
          if (w_last_issue) begin
            r_state       <= S_DRAIN;
            r_issue_valid <= 1'b0;
            r_dcnt        <= '0;
          end else if (r_ph == PW'(P - 1)) begin
            r_ph          <= '0;
            r_issue_valid <= 1'b1;
            r_issue_row   <= w_next_row;
            r_nbr         <= f_mask(w_next_row);
            if (w_last_row) begin
              r_sweep <= r_sweep + SW'(1);
            end
          end else begin
            r_ph          <= r_ph + PW'(1);
            r_issue_valid <= 1'b0;
          end
        end
        S_DRAIN: begin
          // Count to the cycle of the final write-back, then present
          // x[0] on the next cycle.
          if (r_dcnt == DW'(LAT - 1)) begin
            r_state     <= S_OUT;
            r_out_valid <= 1'b1;
            r_out_addr  <= '0;
          end else begin
            r_dcnt <= r_dcnt + DW'(1);
          end
        end
        S_OUT: begin
          if (r_out_valid && out_ready) begin
            if (r_out_addr == IDXW'(N - 1)) begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
              r_out_addr  <= '0;
              r_done      <= 1'b1;
            end else begin
              r_out_addr <= r_out_addr + IDXW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Issue flag and row travel alongside the compute unit; the last
  // stage is the write-back strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pv <= '0;
      for (int k = 0; k < LAT; k++) begin
        r_prow[k] <= '0;
      end
    end else begin
      r_pv[0]   <= r_issue_valid;
      r_prow[0] <= r_issue_row;
      for (int k = 1; k < LAT; k++) begin
        r_pv[k]   <= r_pv[k-1];
        r_prow[k] <= r_prow[k-1];
      end
    end
  end

endmodule

// File: tb/tb_gsim_sequencer.sv
// tb_gsim_sequencer: scoreboard bench for gsim_sequencer.
// Stimulus queues expected events; a negedge monitor pops and compares.

module tb_gsim_sequencer;

  localparam int N    = 16;
  localparam int ITER = 50;
  localparam int LAT  = 2;
  localparam int IDXW = 4;
`ifdef GSIM_SEQ_PIPELINED_EN
  localparam int P = 1;
`else
  localparam int P = LAT + 1;
`endif

  logic            clk;
  logic            reset;
  logic            in_en;
  logic            b_wr_en;
  logic [IDXW-1:0] b_wr_addr;
  logic            issue_valid;
  logic [IDXW-1:0] issue_row;
  logic [5:0]      nbr_valid;
  logic            x_wr_en;
  logic [IDXW-1:0] x_wr_addr;
  logic            out_valid;
  logic            out_ready;
  logic [IDXW-1:0] out_addr;
  logic            busy;
  logic            done;

  gsim_sequencer #(
    .N(N), .ITER(ITER), .LAT(LAT), .IDXW(IDXW)
  ) dut (
    .clk(clk), .reset(reset), .in_en(in_en),
    .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr),
    .issue_valid(issue_valid), .issue_row(issue_row),
    .nbr_valid(nbr_valid),
    .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .busy(busy), .done(done)
  );

  typedef struct {
    int c;
    int v;
    int a;
  } ev_t;

  ev_t qb[$];
  ev_t qi[$];
  ev_t qx[$];
  ev_t qo[$];
  ev_t qd[$];
  ev_t em;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stall_lo = -1;
  int stall_hi = -2;
  int c0;
  int dc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    end
  end

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d cycle=%0d",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic void unexp(string nm);
    total++;
    bad++;
    $display("FAIL %s unexpected event cycle=%0d", nm, cyc);
  endfunction

  // Expected neighbour mask; edge rows from a hand table.
  function automatic int exp_mask(int i);
    logic [5:0] m;
    case (i)
      0:  m = 6'b010101;
      1:  m = 6'b110101;
      8:  m = 6'b111111;
      15: m = 6'b101010;
      default: begin
        m = '0;
        for (int k = 1; k <= 3; k++) begin
          m[7-2*k] = (i - k >= 0);
          m[6-2*k] = (i + k < N);
        end
      end
    endcase
    return int'(m);
  endfunction

  always @(negedge clk) begin
    if (b_wr_en) begin
      if (qb.size() == 0) unexp("b_wr");
      else begin
        em = qb.pop_front();
        chk("b_cyc", cyc, em.c);
        chk("b_addr", int'(b_wr_addr), em.v);
      end
    end
    if (issue_valid) begin
      if (qi.size() == 0) unexp("issue");
      else begin
        em = qi.pop_front();
        chk("iss_cyc", cyc, em.c);
        chk("iss_row", int'(issue_row), em.v);
        chk("iss_nbr", int'(nbr_valid), em.a);
      end
    end
    if (x_wr_en) begin
      if (qx.size() == 0) unexp("x_wr");
      else begin
        em = qx.pop_front();
        chk("x_cyc", cyc, em.c);
        chk("x_addr", int'(x_wr_addr), em.v);
      end
    end
    if (out_valid) begin
      if (qo.size() == 0) unexp("out");
      else begin
        em = qo.pop_front();
        chk("out_cyc", cyc, em.c);
        chk("out_addr", int'(out_addr), em.v);
      end
    end
    if (done) begin
      if (qd.size() == 0) unexp("done");
      else begin
        em = qd.pop_front();
        chk("done_cyc", cyc, em.c);
        chk("done_busy", int'(busy), 0);
      end
    end
  end

  task automatic chk_zero();
    chk("z_b_wr_en", int'(b_wr_en), 0);
    chk("z_b_wr_addr", int'(b_wr_addr), 0);
    chk("z_issue_valid", int'(issue_valid), 0);
    chk("z_issue_row", int'(issue_row), 0);
    chk("z_nbr_valid", int'(nbr_valid), 0);
    chk("z_x_wr_en", int'(x_wr_en), 0);
    chk("z_x_wr_addr", int'(x_wr_addr), 0);
    chk("z_out_valid", int'(out_valid), 0);
    chk("z_out_addr", int'(out_addr), 0);
    chk("z_busy", int'(busy), 0);
    chk("z_done", int'(done), 0);
  endtask

  task automatic do_load(input bit pause, output int c_first);
    int last;
    last = 0;
    for (int w = 0; w < N; w++) begin
      @(posedge clk);
      #1;
      in_en = 1'b1;
      qb.push_back(ev_t'{cyc, w, 0});
      last = cyc;
      if (pause && w == 7) begin
        repeat (3) begin
          @(posedge clk);
          #1;
          in_en = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    in_en = 1'b0;
    c_first = last + 1;
  endtask

  task automatic expect_solve(input int cs, input bit stall,
                              output int dcyc);
    int f;
    int c;
    for (int k = 0; k < ITER * N; k++) begin
      qi.push_back(ev_t'{cs + k * P, k % N, exp_mask(k % N)});
      qx.push_back(ev_t'{cs + k * P + LAT, k % N, 0});
    end
    f = cs + (ITER * N - 1) * P + LAT + 1;
    c = f;
    if (stall) begin
      stall_lo = f + 4;
      stall_hi = f + 8;
    end else begin
      stall_lo = -1;
      stall_hi = -2;
    end
    for (int a = 0; a < N; a++) begin
      if (stall && a == 4) begin
        repeat (5) begin
          qo.push_back(ev_t'{c, 4, 0});
          c++;
        end
      end
      qo.push_back(ev_t'{c, a, 0});
      c++;
    end
    qd.push_back(ev_t'{c, 0, 0});
    dcyc = c;
  endtask

  task automatic finish_solve(input int dcyc);
    while (cyc < dcyc + 5) @(posedge clk);
    #1;
    chk("left_b", qb.size(), 0);
    chk("left_issue", qi.size(), 0);
    chk("left_x", qx.size(), 0);
    chk("left_out", qo.size(), 0);
    chk("left_done", qd.size(), 0);
    chk("end_busy", int'(busy), 0);
    chk("end_out_valid", int'(out_valid), 0);
  endtask

  initial begin
    reset = 1'b1;
    in_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // continuous load, backpressure at out_addr 4
    do_load(1'b0, c0);
    expect_solve(c0, 1'b1, dc);
    finish_solve(dc);

    // paused load, stray in_en while iterating
    do_load(1'b1, c0);
    expect_solve(c0, 1'b0, dc);
    repeat (5) @(posedge clk);
    #1;
    chk("iter_busy", int'(busy), 1);
    in_en = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    in_en = 1'b0;
    finish_solve(dc);

    // reset during sweep 10, then a full solve
    do_load(1'b0, c0);
    expect_solve(c0, 1'b0, dc);
    while (cyc < c0 + 165 * P) @(posedge clk);
    #1;
    reset = 1'b1;
    qb.delete();
    qi.delete();
    qx.delete();
    qo.delete();
    qd.delete();
    stall_lo = -1;
    stall_hi = -2;
    #1;
    chk_zero();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_busy", int'(busy), 0);
    do_load(1'b0, c0);
    expect_solve(c0, 1'b0, dc);
    finish_solve(dc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gsim_sequencer.md
Name: gsim_sequencer

Overview:
Control sequencer for the banded Gauss-Seidel solver datapath: 16 unknowns, coefficients 20 / -13 / 6 / -1, and a pipelined compute unit of depth LAT.
- Captures the N right-hand-side words into the register file.
- Issues one row update at a time, with neighbour-valid masks for the matrix edges.
- Tracks the in-flight pipeline and generates write-back strobes.
- Counts ITER sweeps, then streams the solution out under a valid/ready handshake.

Parameters:
N, 16, number of unknowns/rows; must be >=4.
ITER, 50, number of full sweeps before output; must be >=1.
LAT, 2, compute-unit latency in cycles, from issue to result; must be >=1.
IDXW, 4, row-index width; must satisfy 2^IDXW >= N.

Ports:
clk  in  1  clock
reset  in  1  reset; asynchronous, active-high
in_en  in  1  b word valid on the data bus this cycle
b_wr_en  out  1  register-file b write strobe
b_wr_addr  out  IDXW  b write index
issue_valid  out  1  compute unit evaluates row issue_row this cycle
issue_row  out  IDXW  row being issued
nbr_valid  out  6  neighbour mask, bit order {i-1,i+1,i-2,i+2,i-3,i+3}; 0 = datapath forces the term to zero
x_wr_en  out  1  write compute result into x register file
x_wr_addr  out  IDXW  x write index
out_valid  out  1  x[out_addr] presented on x_out
out_ready  in  1  downstream accepts the output word
out_addr  out  IDXW  x read index for output streaming
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the last output word is accepted

Behaviour:
- Reset (asynchronous) forces state IDLE and clears all counters and pipeline flags. Every output resets to 0. Reset mid-operation abandons the solve; no residual x writes occur.
- States: IDLE, LOAD, ITER, DRAIN, OUTPUT.
- IDLE:
  - in_en=1 stores the word at b_wr_addr=0 and moves to LOAD with load_cnt=1.
  - If N==1 the block would go straight to ITER, but N>=4 is required.
- LOAD:
  - Each cycle with in_en=1 drives b_wr_en=1 with b_wr_addr=load_cnt, then increments load_cnt.
  - Cycles with in_en=0 pause the load without error.
  - After word N-1 is accepted, the next state is ITER.
  - x registers are also cleared to zero by the datapath when b word 0 is written.
- ITER:
  - Rows are issued 0..N-1, sweep after sweep, with a constant issue interval P between issues.
  - issue_valid is high only on issue cycles; issue_row holds its value between issues.
  - nbr_valid bit for row i±k is 1 iff 0 <= i±k <= N-1.
  - After row N-1 of sweep ITER-1 is issued, the next state is DRAIN.
- Pipeline tracking:
  - x_wr_en(t) = issue_valid(t-LAT).
  - x_wr_addr(t) = issue_row(t-LAT).
  - This is implemented as a LAT-deep shift register of the valid flag and row index.
- DRAIN: wait until the last x_wr_en has fired, then go to OUTPUT on the following cycle.
- OUTPUT:
  - out_valid=1 and out_addr starts at 0.
  - Advance on out_valid&&out_ready.
  - After index N-1 is accepted: done=1 for one cycle, out_valid=0, return to IDLE.
  - out_addr is held stable while out_ready=0.
- in_en outside IDLE/LOAD is ignored; it does not start a new load.
- Counters:
  - sweep_cnt has width $clog2(ITER+1) and wraps nowhere; ITER is terminal.
  - The row counter wraps N-1 -> 0 and increments sweep_cnt on that wrap.
- Timing: let c0 be the first issue cycle, the cycle after the last b word.
  - Row r of sweep s issues at c0 + (s*N + r)*P.
  - The first out_valid occurs at c0 + (ITER*N-1)*P + LAT + 1.

Optional Feature:
GSIM_SEQ_PIPELINED_EN
- Undefined (strict Gauss-Seidel): P = LAT+1.
  - Every row reads its predecessor's freshly written value.
  - A sweep takes N*(LAT+1) cycles.
- Defined: P = 1; rows issue back-to-back.
  - Reads of i-1..i-LAT return the previous sweep's value (hybrid Jacobi/GS).
  - A sweep takes N cycles.
  - The DRAIN state still waits LAT cycles.

Test Plan:
- Load 16 words with in_en continuous (N=16, LAT=2, ITER=50, strict):
  - b_wr_addr runs 0..15.
  - issue_valid for row 0 is first asserted 1 cycle after the last word.
  - out_valid is first asserted at c0+2400.
- Load with in_en deasserted for 3 cycles after word 7 -> b_wr_en pauses, no address is skipped, and ITER starts only after word 15.
- Edge masks:
  - row 0 -> nbr_valid=6'b010101.
  - row 1 -> 6'b110101.
  - row 15 -> 6'b101010.
  - row 8 -> 6'b111111.
  - Each x_wr_addr equals issue_row delayed exactly 2 cycles.
- Output backpressure: hold out_ready=0 for 5 cycles at out_addr=4 -> out_addr stays 4 and out_valid stays 1.
  - Completion: all 16 accepted -> done pulse, then busy=0.
- Assert reset during sweep 10 -> all outputs 0 immediately and no further x_wr_en. A new 16-word load then completes a full solve.
- With GSIM_SEQ_PIPELINED_EN, ITER=50 -> issue_valid is continuously high for 800 cycles and out_valid is first asserted at c0+802.
